// File: rtl/pry2oht_pkg.sv
// Shared types and helpers for the pry2oht round-robin arbiter: scan-direction
// names, priority-encoder styles, FSM states and the post-grant mask function.
package pry2oht_pkg;

  localparam string DIR_LSB   = "LSB";
  localparam string DIR_MSB   = "MSB";
  localparam int    MAX_WIDTH = 64;

  typedef enum int {
    IMP_LOOP   = 0,
    IMP_VECTOR = 1,
    IMP_ADDER  = 2
  } imp_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Channels still ahead of k in scan order; all zeros when k was the last one.
  function automatic logic [MAX_WIDTH-1:0] mask_after(input int k, input int width,
                                                      input logic dir_msb);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (dir_msb) m[i] = (i < k);
      else         m[i] = (i > k) && (i < width);
    end
    return m;
  endfunction

endpackage

// File: rtl/pry2oht_rrarb_oht2bin.sv
// Combinational one-hot to binary encoder; an all-zero input yields index 0.
module oht2bin #(
  parameter  int WIDTH = 8,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_oht,
  output logic [IW-1:0]    o_bin
);

  // NOTE: o_bin gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    o_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_oht[i]) o_bin = o_bin | IW'(i);
    end
  end

endmodule

// File: rtl/pry2oht_rrarb.sv
// Round-robin arbiter: masked priority-to-one-hot selection, registered one-hot
// grant held until release or optional hold timeout.
module pry2oht_rrarb
  import pry2oht_pkg::*;
#(
  parameter  int    WIDTH          = 8,
  parameter  string DIRECTION      = "LSB",
  parameter  int    IMPLEMENTATION = 0,
  parameter  int    HOLD_MAX       = 0,
  localparam int    IW             = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             rel,
  output logic [WIDTH-1:0] gnt,
  output logic             vld,
  output logic [IW-1:0]    idx,
  output logic             tmo
);

  localparam logic C_MSB = (DIRECTION == DIR_MSB);

  if (DIRECTION != DIR_LSB && DIRECTION != DIR_MSB) begin : g_bad_dir
    $fatal(1, "pry2oht_rrarb: DIRECTION must be \"LSB\" or \"MSB\"");
  end
  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $fatal(1, "pry2oht_rrarb: WIDTH out of range");
  end
  if (HOLD_MAX < 0 || HOLD_MAX > 65535) begin : g_bad_hold
    $fatal(1, "pry2oht_rrarb: HOLD_MAX out of range");
  end

  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] sel_loop(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    logic             found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      int b;
      b = C_MSB ? (WIDTH - 1 - i) : i;
      if (v[b] && !found) begin
        r[b]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Smear the first set bit toward the far end, then keep only its edge.
  function automatic logic [WIDTH-1:0] sel_vector(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] s;
    s = C_MSB ? rev(v) : v;
    for (int sh = 1; sh < WIDTH; sh = sh * 2) s = s | (s << sh);
    s = s & ~(s << 1);
    return C_MSB ? rev(s) : s;
  endfunction

  function automatic logic [WIDTH-1:0] sel_adder(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] s;
    s = C_MSB ? rev(v) : v;
    s = s & (~s + WIDTH'(1));
    return C_MSB ? rev(s) : s;
  endfunction

  state_e           r_state;
  logic [WIDTH-1:0] r_gnt;
  logic [WIDTH-1:0] r_mask;
  logic [IW-1:0]    r_idx;
  logic             r_vld;

  logic [WIDTH-1:0] w_mask_next, w_eff_mask, w_masked, w_sel_m, w_sel_u, w_next;
  logic [IW-1:0]    w_next_idx;
  logic             w_any, w_timeout, w_exit, w_load;

  // In BUSY the candidate grant is scored against the mask the exit would install.
  assign w_mask_next = WIDTH'(mask_after(int'(r_idx), WIDTH, C_MSB));
  assign w_eff_mask  = (r_state == ST_BUSY) ? w_mask_next : r_mask;
  assign w_masked    = req & w_eff_mask;
  assign w_any       = |req;
  assign w_next      = (|w_masked) ? w_sel_m : w_sel_u;
  assign w_exit      = (r_state == ST_BUSY) && (rel || w_timeout);
  assign w_load      = w_any && ((r_state == ST_IDLE) || w_exit);

  if (IMPLEMENTATION == int'(IMP_LOOP)) begin : g_loop
    assign w_sel_m = sel_loop(w_masked);
    assign w_sel_u = sel_loop(req);
  end else if (IMPLEMENTATION == int'(IMP_VECTOR)) begin : g_vector
    assign w_sel_m = sel_vector(w_masked);
    assign w_sel_u = sel_vector(req);
  end else if (IMPLEMENTATION == int'(IMP_ADDER)) begin : g_adder
    assign w_sel_m = sel_adder(w_masked);
    assign w_sel_u = sel_adder(req);
  end else begin : g_bad_imp
    $fatal(1, "pry2oht_rrarb: IMPLEMENTATION must be 0, 1 or 2");
    assign w_sel_m = '0;
    assign w_sel_u = '0;
  end

  oht2bin #(.WIDTH(WIDTH)) u_enc (
    .i_oht (w_next),
    .o_bin (w_next_idx)
  );

  if (HOLD_MAX == 0) begin : g_no_hold
    assign w_timeout = 1'b0;
  end else begin : g_hold
    localparam int CW = $clog2(HOLD_MAX + 1);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
      if (rst)                                  r_cnt <= '0;
      else if (w_load)                          r_cnt <= '0;
      else if (r_state == ST_BUSY && !w_exit &&
               r_cnt != CW'(HOLD_MAX - 1))      r_cnt <= r_cnt + CW'(1);
    end

    assign w_timeout = (r_state == ST_BUSY) && !rel && (r_cnt == CW'(HOLD_MAX - 1));
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_vld   <= 1'b0;
      r_idx   <= '0;
      r_mask  <= '1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_next;
            r_vld   <= 1'b1;
            r_idx   <= w_next_idx;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_exit) begin
            r_mask <= w_mask_next;
            if (w_any) begin
              r_gnt <= w_next;
              r_idx <= w_next_idx;
            end else begin
              r_gnt   <= '0;
              r_vld   <= 1'b0;
              r_idx   <= '0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt = r_gnt;
  assign vld = r_vld;
  assign idx = r_idx;
  assign tmo = w_timeout && !rst;

endmodule

// File: tb/tb_pry2oht_rrarb.sv
// Directed bench for pry2oht_rrarb: several parameterisations share one stimulus
// stream and are checked against hand-computed grant sequences.
module tb_pry2oht_rrarb;

  logic       clk = 1'b0;
  logic       rst, rel;
  logic [3:0] req;

  logic [3:0] a_gnt, h_gnt, m_gnt, v_gnt, d_gnt;
  logic [1:0] a_idx, h_idx, m_idx, v_idx, d_idx;
  logic       a_vld, h_vld, m_vld, v_vld, d_vld;
  logic       a_tmo, h_tmo, m_tmo, v_tmo, d_tmo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pry2oht_rrarb #(.WIDTH(4), .DIRECTION("LSB"), .IMPLEMENTATION(0), .HOLD_MAX(0)) u_a (
    .clk(clk), .rst(rst), .req(req), .rel(rel),
    .gnt(a_gnt), .vld(a_vld), .idx(a_idx), .tmo(a_tmo));
  pry2oht_rrarb #(.WIDTH(4), .DIRECTION("LSB"), .IMPLEMENTATION(0), .HOLD_MAX(3)) u_h (
    .clk(clk), .rst(rst), .req(req), .rel(rel),
    .gnt(h_gnt), .vld(h_vld), .idx(h_idx), .tmo(h_tmo));
  pry2oht_rrarb #(.WIDTH(4), .DIRECTION("MSB"), .IMPLEMENTATION(0), .HOLD_MAX(0)) u_m (
    .clk(clk), .rst(rst), .req(req), .rel(rel),
    .gnt(m_gnt), .vld(m_vld), .idx(m_idx), .tmo(m_tmo));
  pry2oht_rrarb #(.WIDTH(4), .DIRECTION("LSB"), .IMPLEMENTATION(1), .HOLD_MAX(0)) u_v (
    .clk(clk), .rst(rst), .req(req), .rel(rel),
    .gnt(v_gnt), .vld(v_vld), .idx(v_idx), .tmo(v_tmo));
  pry2oht_rrarb #(.WIDTH(4), .DIRECTION("LSB"), .IMPLEMENTATION(2), .HOLD_MAX(0)) u_d (
    .clk(clk), .rst(rst), .req(req), .rel(rel),
    .gnt(d_gnt), .vld(d_vld), .idx(d_idx), .tmo(d_tmo));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] g, input logic [1:0] i,
                     input logic v, input logic [3:0] eg, input logic [1:0] ei);
    check({tag, ".gnt"}, 32'(g), 32'(eg));
    check({tag, ".idx"}, 32'(i), 32'(ei));
    check({tag, ".vld"}, 32'(v), 32'(|eg));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    rel = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [3:0] lsb_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] msb_seq [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
  logic [1:0] lsb_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] msb_idx [5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};

  initial begin
    do_reset();
    chk("rst_a", a_gnt, a_idx, a_vld, 4'b0000, 2'd0);
    chk("rst_m", m_gnt, m_idx, m_vld, 4'b0000, 2'd0);
    check("rst_a.tmo", 32'(a_tmo), 32'd0);
    check("rst_h.tmo", 32'(h_tmo), 32'd0);

    // Full rotation with release every cycle, all parameterisations at once.
    req = 4'b1111;
    rel = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      chk($sformatf("rot%0d_a", s), a_gnt, a_idx, a_vld, lsb_seq[s], lsb_idx[s]);
      chk($sformatf("rot%0d_v", s), v_gnt, v_idx, v_vld, lsb_seq[s], lsb_idx[s]);
      chk($sformatf("rot%0d_d", s), d_gnt, d_idx, d_vld, lsb_seq[s], lsb_idx[s]);
      chk($sformatf("rot%0d_h", s), h_gnt, h_idx, h_vld, lsb_seq[s], lsb_idx[s]);
      chk($sformatf("rot%0d_m", s), m_gnt, m_idx, m_vld, msb_seq[s], msb_idx[s]);
    end

    // Grant holds while req drops; release then rotates to ch2.
    do_reset();
    req = 4'b0101;
    step();
    chk("hold0_a", a_gnt, a_idx, a_vld, 4'b0001, 2'd0);
    req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c % 3 == 0) chk($sformatf("hold%0d_a", c + 1), a_gnt, a_idx, a_vld, 4'b0001, 2'd0);
    end
    req = 4'b0100;
    rel = 1'b1;
    step();
    chk("hold_rel_a", a_gnt, a_idx, a_vld, 4'b0100, 2'd2);
    chk("hold_rel_d", d_gnt, d_idx, d_vld, 4'b0100, 2'd2);
    rel = 1'b0;

    // Hold timeout of 3 cycles on the HOLD_MAX=3 instance.
    do_reset();
    req = 4'b0011;
    step();
    chk("to1_h", h_gnt, h_idx, h_vld, 4'b0001, 2'd0);
    check("to1_h.tmo", 32'(h_tmo), 32'd0);
    step();
    check("to2_h.tmo", 32'(h_tmo), 32'd0);
    step();
    chk("to3_h", h_gnt, h_idx, h_vld, 4'b0001, 2'd0);
    check("to3_h.tmo", 32'(h_tmo), 32'd1);
    check("to3_a.tmo", 32'(a_tmo), 32'd0);
    step();
    chk("to4_h", h_gnt, h_idx, h_vld, 4'b0010, 2'd1);
    check("to4_h.tmo", 32'(h_tmo), 32'd0);
    chk("to4_a", a_gnt, a_idx, a_vld, 4'b0001, 2'd0);
    step();
    step();
    check("to6_h.tmo", 32'(h_tmo), 32'd1);
    step();
    chk("to7_h", h_gnt, h_idx, h_vld, 4'b0001, 2'd0);

    // Release coinciding with timeout: rel wins, no tmo pulse.
    step();
    step();
    check("tr_pre_h.tmo", 32'(h_tmo), 32'd1);
    rel = 1'b1;
    #1;
    check("tr_h.tmo", 32'(h_tmo), 32'd0);
    step();
    chk("tr_h", h_gnt, h_idx, h_vld, 4'b0010, 2'd1);
    rel = 1'b0;

    // Release while idle must not move the pointer.
    do_reset();
    rel = 1'b1;
    step();
    chk("idle_rel_a", a_gnt, a_idx, a_vld, 4'b0000, 2'd0);
    rel = 1'b0;
    req = 4'b0011;
    step();
    chk("idle_rel2_a", a_gnt, a_idx, a_vld, 4'b0001, 2'd0);

    // Reset mid-grant on ch2, for all three encoder styles.
    do_reset();
    req = 4'b1111;
    rel = 1'b1;
    step();
    step();
    step();
    chk("mid_a", a_gnt, a_idx, a_vld, 4'b0100, 2'd2);
    chk("mid_v", v_gnt, v_idx, v_vld, 4'b0100, 2'd2);
    chk("mid_d", d_gnt, d_idx, d_vld, 4'b0100, 2'd2);
    rst = 1'b1;
    step();
    chk("mrst_a", a_gnt, a_idx, a_vld, 4'b0000, 2'd0);
    chk("mrst_v", v_gnt, v_idx, v_vld, 4'b0000, 2'd0);
    chk("mrst_d", d_gnt, d_idx, d_vld, 4'b0000, 2'd0);
    rst = 1'b0;
    rel = 1'b0;
    step();
    chk("mnew_a", a_gnt, a_idx, a_vld, 4'b0001, 2'd0);
    chk("mnew_v", v_gnt, v_idx, v_vld, 4'b0001, 2'd0);
    chk("mnew_d", d_gnt, d_idx, d_vld, 4'b0001, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pry2oht_rrarb.md
Name: pry2oht_rrarb

Overview:
- Parametrised round-robin arbiter built from masked priority-to-one-hot selection.
- N requesters compete; one registered one-hot grant is held until released.
- A rotating priority pointer gives fairness; an optional hold timeout stops one requester from starving the others.
- Sits in front of shared resources such as bus ports and memory banks.

Parameters:
- WIDTH, 8, number of requesters (>=2).
- DIRECTION, "LSB", sets the priority scan order. "LSB" scans upward from the pointer; "MSB" scans downward. Any other value is a $fatal at elaboration.
- IMPLEMENTATION, 0, internal priority-to-one-hot style: 0 loop, 1 vector, 2 adder. Any other value is a $fatal. All styles are functionally identical.
- HOLD_MAX, 0, maximum grant duration in cycles. 0 means unlimited; otherwise the range is 1..65535.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  WIDTH  request vector, level-sensitive.
- rel  input  1  release of the current grant; ignored while no grant is held.
- gnt  output  WIDTH  registered one-hot grant; all zeros when idle.
- vld  output  1  grant held; equals |gnt.
- idx  output  $clog2(WIDTH)  binary index of the gnt bit; 0 when idle.
- tmo  output  1  one-cycle pulse, asserted in the cycle a grant is revoked by timeout.

Behaviour:
- Reset values: gnt=0, vld=0, idx=0, tmo=0, pointer mask=all ones, hold counter=0, state IDLE.
- Reset priority after reset: channel 0 is highest for LSB; channel WIDTH-1 is highest for MSB.
- State IDLE:
  - If |req, the grant is computed combinationally from req and is registered at the next edge (latency 1 cycle).
  - Next state is BUSY.
- State BUSY:
  - gnt holds stable regardless of req. Dropping req does not revoke the grant.
  - Exit occurs on rel=1, or on timeout: HOLD_MAX!=0 and counter==HOLD_MAX-1 with rel=0.
  - On exit, the pointer updates from the granted channel k.
  - If |req in the exit cycle, a new grant is computed against the updated mask and registered at the same edge (back-to-back, no idle bubble). Next state is BUSY.
  - If no requests are pending, gnt clears and the next state is IDLE.
- Grant selection:
  - m = req & mask. If m != 0, the grant is prio(m); otherwise it is prio(req).
  - prio() is rightmost-one for LSB and leftmost-one for MSB.
- Mask update after granting channel k:
  - LSB: bits k+1..WIDTH-1 set.
  - MSB: bits 0..k-1 set.
  - When k is the last channel in scan order the mask is all zeros, which wraps to the full req vector.
- Hold counter:
  - Clears on every new grant and increments each BUSY cycle without exit.
  - It saturates and never wraps.
  - The width is $clog2(HOLD_MAX+1). The counter is absent when HOLD_MAX=0.
- Timeout:
  - tmo=1 in the cycle the timeout exit is taken, aligned with gnt changing at the next edge.
  - The revoked channel is moved to lowest priority, exactly as on rel.
- rel and timeout in the same cycle: rel wins and tmo=0.
- rel while IDLE: no effect.
- rst mid-grant: gnt drops at the next edge and the mask returns to all ones; rst overrides rel and req.
- A single requester re-requesting is re-granted immediately on exit; fairness applies only among concurrent requesters.
- idx is registered alongside gnt; there is no combinational path from req to outputs.

Decomposition:
- Shared package pry2oht_pkg holds:
  - the DIRECTION string constants "LSB"/"MSB";
  - an IMPLEMENTATION enum (IMP_LOOP=0, IMP_VECTOR=1, IMP_ADDER=2);
  - the function mask_after(k, WIDTH, DIRECTION).
- One sub-module, oht2bin, is a combinational one-hot-to-binary encoder used for idx.
- The two priority selections (masked and unmasked) are generate branches inside the top level, switched by IMPLEMENTATION.

Test Plan (WIDTH=4, LSB unless noted):
- Reset, then req=4'b1111 with rel pulsed every cycle:
  - gnt sequence is 0001, 0010, 0100, 1000, 0001.
  - vld stays high throughout, idx runs 0,1,2,3,0, and no idle cycle appears.
- req=4'b0101 with grant on ch0, then req drops to 4'b0001 with rel=0 for 10 cycles:
  - gnt stays 0001.
  - After rel with req=4'b0100, the next gnt is 0100.
- HOLD_MAX=3, req=4'b0011, rel never asserted:
  - gnt=0001 for 3 cycles, tmo pulses in the 3rd cycle, then gnt=0010.
  - After another 3 cycles the grant returns to 0001.
- HOLD_MAX=3 with rel and timeout in the same cycle: tmo=0 and the rotation is normal.
- DIRECTION="MSB", req=4'b1111 with rel every cycle: gnt sequence is 1000, 0100, 0010, 0001, 1000.
- Reset asserted mid-grant on ch2 with req=4'b1111:
  - The next cycle shows gnt=0, vld=0, idx=0.
  - After release, the first grant is 0001.
  - Repeat this scenario for IMPLEMENTATION 0, 1 and 2; the output traces must be identical.
